// File: rtl/instr_fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage (master) and imem (slave).
// One request is outstanding at a time; valid is a one-cycle response pulse.
interface instr_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/instr_fetch_stage.sv
// MIPS fetch stage with IF/ID register: PC, variable-latency imem fetch FSM,
// stall hold buffer, flush bubbles and branch/jump redirect with stale-response drop.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  instr_fetch_stage_if.master  imem,
  output logic [31:0]          instr_o,
  output logic [15:0]          imm_o,
  output logic [31:0]          pc_plus4_o,
  output logic                 valid_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        deliver;
  logic [31:0] deliver_word;
  logic [31:0] pc_inc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_buf_d   = hold_buf_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    deliver      = 1'b0;
    deliver_word = NOP_INSTR;
    pc_inc       = pc_q + 32'd4;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ, S_WAIT: begin
        if (imem.valid) begin
          if (redirect_i) begin
            state_d = S_REQ;
          end else if (stall_i) begin
            hold_buf_d = imem.data;
            state_d    = S_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem.data;
            pc_d         = pc_inc;
            state_d      = S_REQ;
          end
        end else if (redirect_i) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_REQ;
        end else if (!stall_i) begin
          deliver      = 1'b1;
          deliver_word = hold_buf_q;
          pc_d         = pc_inc;
          state_d      = S_REQ;
        end
      end
      S_DROP: if (imem.valid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    // A redirect always wins the PC, whatever the FSM decided above.
    if (redirect_i) pc_d = redirect_pc_i & ~32'd3;

    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (deliver) begin
      instr_d    = deliver_word;
      pc_plus4_d = pc_inc;
      valid_d    = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    req_d = (state_d == S_REQ) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      hold_buf_q <= '0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_buf_q <= hold_buf_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = pc_q;
  assign instr_o    = instr_q;
  assign imm_o      = instr_q[15:0];
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, hand-written reset
// sequences, then randomized traffic against a flag-based reference model.
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redir = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] instr, pc4;
  logic [15:0] imm;
  logic        valid;

  instr_fetch_stage_if imem ();

  instr_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .redirect_i(redir), .redirect_pc_i(rpc), .imem(imem),
    .instr_o(instr), .imm_o(imm), .pc_plus4_o(pc4), .valid_o(valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        mvalid;
    logic [31:0] mdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr, exp_pc4;
  } vec_t;

  vec_t vecs [19];

  // Reference model: a live fetch, a stale fetch, or a buffered word, plus the IF/ID contents.
  logic        m_started, m_fetching, m_stale, m_buffered;
  logic [31:0] m_pc, m_buf, m_instr, m_pc4;
  logic        m_valid;

  function automatic vec_t mkv(logic s, logic f, logic r, logic [31:0] rp, logic mv,
                               logic [31:0] md, logic er, logic [31:0] ea, logic ev,
                               logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.stall = s; v.flush = f; v.redir = r; v.rpc = rp; v.mvalid = mv; v.mdata = md;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc4 = ep;
    return v;
  endfunction

  function automatic logic [31:0] memWord(logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h1234_5678;
  endfunction

  task automatic applyStimulus(input logic s, input logic f, input logic r,
                               input logic [31:0] rp, input logic mv, input logic [31:0] md);
    stall = s; flush = f; redir = r; rpc = rp;
    imem.valid = mv; imem.data = md;
  endtask

  task automatic checkOutput(input string tag, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", tag, field, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    checkOutput(tag, "req",   {31'd0, imem.req}, {31'd0, er});
    checkOutput(tag, "addr",  imem.addr, ea);
    checkOutput(tag, "valid", {31'd0, valid}, {31'd0, ev});
    checkOutput(tag, "instr", instr, ei);
    checkOutput(tag, "imm",   {16'd0, imm}, {16'd0, ei[15:0]});
    checkOutput(tag, "pc4",   pc4, ep);
  endtask

  task automatic modelReset();
    m_started = 0; m_fetching = 0; m_stale = 0; m_buffered = 0;
    m_pc = RESET_PC; m_buf = '0; m_instr = NOP; m_pc4 = '0; m_valid = 0;
  endtask

  task automatic modelStep(input logic s, input logic f, input logic r,
                           input logic [31:0] rp, input logic v, input logic [31:0] d);
    logic        deliver = 1'b0;
    logic [31:0] word = NOP;
    logic [31:0] old_plus4 = m_pc + 32'd4;
    logic [31:0] new_pc = m_pc;
    if (!m_started) begin
      m_started = 1; m_fetching = 1;
    end else if (m_fetching) begin
      if (v && !r) begin
        if (s) begin m_buffered = 1; m_buf = d; m_fetching = 0; end
        else begin deliver = 1; word = d; new_pc = old_plus4; end
      end else if (!v && r) begin
        m_fetching = 0; m_stale = 1;
      end
    end else if (m_buffered) begin
      if (r) begin m_buffered = 0; m_fetching = 1; end
      else if (!s) begin
        deliver = 1; word = m_buf; new_pc = old_plus4; m_buffered = 0; m_fetching = 1;
      end
    end else if (m_stale && v) begin
      m_stale = 0; m_fetching = 1;
    end
    if (r) new_pc = {rp[31:2], 2'b00};
    if (f) begin m_instr = NOP; m_valid = 0; end
    else if (!s) begin
      if (deliver) begin m_instr = word; m_valid = 1; m_pc4 = old_plus4; end
      else begin m_instr = NOP; m_valid = 0; end
    end
    m_pc = new_pc;
  endtask

  initial begin
    logic        mem_pend, prev_valid, v, s, f, r;
    int          mem_cnt, mem_lat;
    logic [31:0] mem_addr, d, rp;

    // stall flush redir rpc | mvalid mdata | req addr valid instr pc4
    vecs[0]  = mkv(0,0,0,32'h0,        0,32'h0,        1,32'h0,        0,NOP,          32'h0);
    vecs[1]  = mkv(0,0,0,32'h0,        1,32'h20080005, 1,32'h4,        1,32'h20080005, 32'h4);
    vecs[2]  = mkv(0,0,0,32'h0,        1,32'h2009FFFF, 1,32'h8,        1,32'h2009FFFF, 32'h8);
    vecs[3]  = mkv(0,0,0,32'h0,        0,32'h0,        1,32'h8,        0,NOP,          32'h8);
    vecs[4]  = mkv(0,0,0,32'h0,        0,32'h0,        1,32'h8,        0,NOP,          32'h8);
    vecs[5]  = mkv(0,0,0,32'h0,        1,32'h8C010010, 1,32'hC,        1,32'h8C010010, 32'hC);
    vecs[6]  = mkv(0,0,0,32'h0,        0,32'h0,        1,32'hC,        0,NOP,          32'hC);
    vecs[7]  = mkv(0,0,1,32'h43,       0,32'h0,        0,32'h40,       0,NOP,          32'hC);
    vecs[8]  = mkv(0,0,0,32'h0,        1,32'hDEADBEEF, 1,32'h40,       0,NOP,          32'hC);
    vecs[9]  = mkv(0,0,0,32'h0,        1,32'h24020007, 1,32'h44,       1,32'h24020007, 32'h44);
    vecs[10] = mkv(1,0,0,32'h0,        1,32'h3C01ABCD, 0,32'h44,       1,32'h24020007, 32'h44);
    vecs[11] = mkv(1,0,0,32'h0,        0,32'h0,        0,32'h44,       1,32'h24020007, 32'h44);
    vecs[12] = mkv(0,0,0,32'h0,        0,32'h0,        1,32'h48,       1,32'h3C01ABCD, 32'h48);
    vecs[13] = mkv(1,1,0,32'h0,        0,32'h0,        1,32'h48,       0,NOP,          32'h48);
    vecs[14] = mkv(0,1,1,32'h100,      1,32'h00221820, 1,32'h100,      0,NOP,          32'h48);
    vecs[15] = mkv(0,0,0,32'h0,        1,32'hAC230000, 1,32'h104,      1,32'hAC230000, 32'h104);
    vecs[16] = mkv(0,0,1,32'hFFFFFFFE, 0,32'h0,        0,32'hFFFFFFFC, 0,NOP,          32'h104);
    vecs[17] = mkv(0,0,0,32'h0,        1,32'h11111111, 1,32'hFFFFFFFC, 0,NOP,          32'h104);
    vecs[18] = mkv(0,0,0,32'h0,        1,32'h2010FFFE, 1,32'h0,        1,32'h2010FFFE, 32'h0);

    applyStimulus(0, 0, 0, '0, 0, '0);
    #1 rst = 1'b0;
    #2 checkAll("reset", 0, RESET_PC, 0, NOP, 32'h0);
    @(negedge clk) rst = 1'b1;

    for (int k = 0; k < 19; k++) begin
      applyStimulus(vecs[k].stall, vecs[k].flush, vecs[k].redir, vecs[k].rpc,
                    vecs[k].mvalid, vecs[k].mdata);
      @(posedge clk); #1;
      checkAll($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_addr,
               vecs[k].exp_valid, vecs[k].exp_instr, vecs[k].exp_pc4);
    end

    // Reset arriving mid-WAIT must take effect without a clock, and a late response is ignored.
    applyStimulus(0, 0, 0, '0, 0, '0);
    @(posedge clk); #1;
    checkAll("prewait", 1, 32'h0, 0, NOP, 32'h0);
    #2 rst = 1'b0;
    #1 checkAll("midreset", 0, RESET_PC, 0, NOP, 32'h0);
    @(negedge clk) rst = 1'b1;
    applyStimulus(0, 0, 0, '0, 1, 32'hBAD0BAD0);
    @(posedge clk); #1;
    checkAll("idlevalid", 1, RESET_PC, 0, NOP, 32'h0);
    applyStimulus(0, 0, 0, '0, 1, 32'h20080005);
    @(posedge clk); #1;
    checkAll("restart", 1, 32'h4, 1, 32'h20080005, 32'h4);

    applyStimulus(0, 0, 0, '0, 0, '0);
    #2 rst = 1'b0;
    modelReset();
    #1 checkAll("reset2", m_fetching, m_pc, m_valid, m_instr, m_pc4);
    @(negedge clk) rst = 1'b1;

    mem_pend = 0; prev_valid = 0; mem_cnt = 0; mem_lat = 1; mem_addr = '0;
    for (int i = 0; i < 2000; i++) begin
      if (prev_valid) mem_pend = 0;
      else if (mem_pend) mem_cnt++;
      if (!mem_pend && imem.req) begin
        mem_pend = 1; mem_cnt = 1; mem_addr = imem.addr; mem_lat = $urandom_range(1, 4);
      end
      v  = mem_pend && (mem_cnt == mem_lat);
      d  = v ? memWord(mem_addr) : $urandom;
      s  = ($urandom_range(0, 9) < 3);
      f  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 9) == 0);
      rp = $urandom;
      applyStimulus(s, f, r, rp, v, d);
      modelStep(s, f, r, rp, v, d);
      prev_valid = v;
      @(posedge clk); #1;
      checkAll($sformatf("rand%0d", i), m_fetching, m_pc, m_valid, m_instr, m_pc4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
